// File: rtl/ap_ctrl_hs_driver.sv
// Initiator for the ap_ctrl_hs block-level handshake: runs a batch of back-to-back
// kernel transactions and records per-transaction latency. Optional watchdog: AP_DRV_TIMEOUT_EN.
module ap_ctrl_hs_driver #(
    parameter int CNT_W       = 16,
    parameter int LAT_W       = 32,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             go,
    input  logic [CNT_W-1:0] num_txn,
    output logic             ap_start,
    output logic             ap_continue,
    input  logic             ap_ready,
    input  logic             ap_done,
    output logic             busy,
    output logic             finish,
    output logic [CNT_W-1:0] txn_count,
    output logic [LAT_W-1:0] last_lat,
    output logic [LAT_W-1:0] max_lat,
    output logic             timeout
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_START     = 2'd1,
        S_WAIT_DONE = 2'd2,
        S_FIN       = 2'd3
    } state_t;

    state_t           state_reg;
    logic             ap_start_reg;
    logic             ap_continue_reg;
    logic             busy_reg;
    logic             finish_reg;
    logic [CNT_W-1:0] rem_reg;
    logic [CNT_W-1:0] txn_count_reg;
    logic [LAT_W-1:0] lat_reg;
    logic [LAT_W-1:0] last_lat_reg;
    logic [LAT_W-1:0] max_lat_reg;

    logic             in_run;
    logic             accept_go;
    logic             enter_start;
    logic             wd_fire;
    logic [LAT_W-1:0] lat_inc;

    assign in_run    = (state_reg == S_START) || (state_reg == S_WAIT_DONE);
    assign accept_go = go && ((state_reg == S_IDLE) || (state_reg == S_FIN));
    // Both the go that starts a non-empty batch and a done with work left re-enter START.
    assign enter_start = (accept_go && (num_txn != '0)) ||
                         (in_run && ap_done && (rem_reg > CNT_W'(1)));
    assign lat_inc   = (lat_reg == '1) ? lat_reg : lat_reg + LAT_W'(1);

`ifdef AP_DRV_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0] wd_reg;
    logic            timeout_reg;

    assign wd_fire = in_run && !ap_done && (wd_reg == WD_W'(TIMEOUT_CYC));

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            wd_reg      <= '0;
            timeout_reg <= 1'b0;
        end else begin
            if (enter_start) begin
                wd_reg <= '0;
            end else if (in_run && (wd_reg != WD_W'(TIMEOUT_CYC))) begin
                wd_reg <= wd_reg + WD_W'(1);
            end
            if (accept_go) begin
                timeout_reg <= 1'b0;
            end else if (wd_fire) begin
                timeout_reg <= 1'b1;
            end
        end
    end

    assign timeout = timeout_reg;
`else
    logic unused_timeout_cyc;
    assign unused_timeout_cyc = (TIMEOUT_CYC != 0);
    assign wd_fire = 1'b0;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_reg       <= S_IDLE;
            ap_start_reg    <= 1'b0;
            ap_continue_reg <= 1'b0;
            busy_reg        <= 1'b0;
            finish_reg      <= 1'b0;
            rem_reg         <= '0;
            txn_count_reg   <= '0;
            lat_reg         <= '0;
            last_lat_reg    <= '0;
            max_lat_reg     <= '0;
        end else begin
            ap_continue_reg <= 1'b1;

            if (enter_start) begin
                lat_reg <= '0;
            end else if (in_run) begin
                lat_reg <= lat_inc;
            end

            case (state_reg)
                S_IDLE, S_FIN: begin
                    if (go) begin
                        txn_count_reg <= '0;
                        max_lat_reg   <= '0;
                        rem_reg       <= num_txn;
                        if (num_txn != '0) begin
                            state_reg    <= S_START;
                            ap_start_reg <= 1'b1;
                            busy_reg     <= 1'b1;
                            finish_reg   <= 1'b0;
                        end else begin
                            state_reg    <= S_FIN;
                            finish_reg   <= 1'b1;
                        end
                    end
                end
                S_START, S_WAIT_DONE: begin
                    // A done seen while still in START implies ready in the same cycle.
                    if (ap_done) begin
                        txn_count_reg <= txn_count_reg + CNT_W'(1);
                        rem_reg       <= rem_reg - CNT_W'(1);
                        last_lat_reg  <= lat_inc;
                        if (lat_inc > max_lat_reg) begin
                            max_lat_reg <= lat_inc;
                        end
                        if (rem_reg > CNT_W'(1)) begin
                            state_reg    <= S_START;
                            ap_start_reg <= 1'b1;
                        end else begin
                            state_reg    <= S_FIN;
                            ap_start_reg <= 1'b0;
                            busy_reg     <= 1'b0;
                            finish_reg   <= 1'b1;
                        end
                    end else if (wd_fire) begin
                        state_reg    <= S_FIN;
                        ap_start_reg <= 1'b0;
                        busy_reg     <= 1'b0;
                        finish_reg   <= 1'b1;
                    end else if ((state_reg == S_START) && ap_ready) begin
                        state_reg    <= S_WAIT_DONE;
                        ap_start_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign ap_start    = ap_start_reg;
    assign ap_continue = ap_continue_reg;
    assign busy        = busy_reg;
    assign finish      = finish_reg;
    assign txn_count   = txn_count_reg;
    assign last_lat    = last_lat_reg;
    assign max_lat     = max_lat_reg;

endmodule

// File: doc/ap_ctrl_hs_driver.md
# ap_ctrl_hs_driver

Synthesizable initiator for the HLS `ap_ctrl_hs` block-level handshake: drives `ap_start`/`ap_continue` into a kernel such as the 12-hour clock core and consumes its `ap_ready`/`ap_done`. It issues a programmed number of back-to-back transactions and measures per-transaction latency. It raises `finish` when the batch completes, so the dataflow monitor can be wired to it directly.

## Interface
- `CNT_W`, 16: width of the transaction count and the transaction counter.
- `LAT_W`, 32: width of the latency counters; saturating.
- `TIMEOUT_CYC`, 1000: watchdog limit in cycles; used only when `AP_DRV_TIMEOUT_EN` is defined.

- `ap_clk`  in  1  sole clock; rising edge.
- `ap_rst_n`  in  1  asynchronous, active-low reset.
- `go`  in  1  single-cycle request to start a batch; ignored while `busy`=1.
- `num_txn`  in  CNT_W  number of transactions; sampled on the accepted `go`.
- `ap_start`  out  1  kernel start; registered.
- `ap_continue`  out  1  tied 1 whenever out of reset (`ap_ctrl_hs`); 0 in reset.
- `ap_ready`  in  1  kernel accepted its inputs.
- `ap_done`  in  1  kernel output valid; single-cycle pulse.
- `busy`  out  1  batch in progress.
- `finish`  out  1  level; batch complete; held until the next accepted `go`.
- `txn_count`  out  CNT_W  completed transactions in the current or last batch.
- `last_lat`  out  LAT_W  latency of the most recent transaction.
- `max_lat`  out  LAT_W  maximum latency in the current or last batch.
- `timeout`  out  1  watchdog fired; sticky until the next `go`.

## Operation
- States:
  - IDLE: reset state; waits for `go`.
  - START: `ap_start`=1; waits for `ap_ready`.
  - WAIT_DONE: `ap_start`=0; waits for `ap_done`.
  - FIN: `finish`=1, `busy`=0; waits for `go`.
- `go` in IDLE or FIN:
  - Clears `txn_count`, `max_lat`, `timeout` and `finish`.
  - Latches `num_txn` into a remaining counter.
  - Goes to START if `num_txn`≠0, otherwise to FIN.
- START with `ap_ready`=1 and `ap_done`=0: go to WAIT_DONE.
- `ap_done`=1 in START or WAIT_DONE:
  - Treated as ready+done.
  - Increments `txn_count` and decrements the remaining counter.
  - Updates `last_lat` and `max_lat`.
  - Goes to START if the remaining count is >0 after the decrement, otherwise to FIN.
- `ap_done` or `ap_ready` while in IDLE or FIN: ignored.
- Latency counter:
  - Cleared on entry to START.
  - Increments every cycle in START or WAIT_DONE, saturating at all-ones.
  - `last_lat` = counter+1 (saturated) in the `ap_done` cycle. The cycle in which `ap_start` rises counts as cycle 1.
- `max_lat` updates with unsigned `>` compare; it holds its value on ties.
- `txn_count` never wraps, because it is bounded by `num_txn`.

## Timing
- Reset values: every output 0. State = IDLE.
- `ap_rst_n` low mid-batch: `ap_start` drops immediately (async); all counters clear; no `finish`.
- `go` sampled at edge k: `busy`=1 and `ap_start`=1 from cycle k+1.
- `ap_start` stays high through the cycle where `ap_ready` is sampled 1. It is low from the next cycle unless a further transaction follows.
- `ap_done` sampled at edge d with more transactions remaining: `ap_start` is high again in cycle d+1 with zero idle gap.
- `ap_done` sampled at edge d on the last transaction:
  - `finish`=1 and `busy`=0 from cycle d+1.
  - `txn_count`, `last_lat` and `max_lat` are valid in the same cycle.
- `go` coinciding with the `finish` assertion edge is impossible, because `busy` is still 1. `go` while in FIN restarts the batch.

## Configuration
- `AP_DRV_TIMEOUT_EN` defined:
  - A watchdog counts cycles in START/WAIT_DONE and clears on entry to START.
  - When the count reaches `TIMEOUT_CYC` without `ap_done`, `timeout`=1, `ap_start`=0 and the state goes to FIN the next cycle.
  - `txn_count` keeps only the completed transactions.
- `AP_DRV_TIMEOUT_EN` undefined: no watchdog logic; `timeout` tied 0; the driver waits indefinitely for `ap_done`.

## Test plan
- Reset, then `go` with `num_txn`=3; kernel asserts ready+done 4 cycles after each `ap_start` rise -> three `ap_start` bursts with no gaps, `last_lat`=`max_lat`=5, `txn_count`=3, `finish`=1 the cycle after the third `ap_done`.
- `num_txn`=0 -> `ap_start` never rises; `finish`=1 one cycle after `go`; `txn_count`=0.
- Ready at cycle 1 of `ap_start`, done at cycle 6, on a single transaction -> `ap_start` high for exactly 1 cycle; `last_lat`=6.
- Latencies 3, 9, 5 on `num_txn`=3 -> `max_lat`=9, `last_lat`=5; `go` pulse asserted mid-batch is ignored.
- `ap_rst_n` pulsed low while in WAIT_DONE -> `ap_start`, `busy`, counters all 0 immediately; a new `go` runs a clean batch.
- With `AP_DRV_TIMEOUT_EN` and `TIMEOUT_CYC`=20, kernel never asserts `ap_done` -> `timeout`=1, `finish`=1, `txn_count`=0 about 21 cycles after `ap_start` rises; without the macro, `busy` stays 1 and `timeout` stays 0.
